// File: rtl/i2c_slave_pkg.sv
// Shared types and bit constants for the I2C slave responder.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK_BIT   = 1'b0;
  localparam logic NACK_BIT  = 1'b1;
  localparam int   ADDR_BITS = 8;

  // Open-drain output: pulling the wire low is the only way to send a 0.
  function automatic logic pull_for(input logic wire_bit);
    return ~wire_bit;
  endfunction

endpackage

// File: rtl/i2c_slave_line_filter.sv
// SCL/SDA synchronizers with edge and START/STOP pulse generation.
// Optional 3-clock stability filter when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1, sda_p0, sda_p1;
  logic scl, scl_q, sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_p0 <= scl_raw;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_raw;
      sda_p1 <= sda_p0;
      scl_q  <= scl;
      sda_q  <= sda;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic scl_p2, scl_p3, sda_p2, sda_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p2 <= 1'b1;
      scl_p3 <= 1'b1;
      sda_p2 <= 1'b1;
      sda_p3 <= 1'b1;
    end else begin
      scl_p2 <= scl_p1;
      scl_p3 <= scl_p2;
      sda_p2 <= sda_p1;
      sda_p3 <= sda_p2;
    end
  end

  // A level is accepted once three consecutive samples agree; otherwise hold.
  assign scl = (scl_p1 == scl_p2 && scl_p2 == scl_p3) ? scl_p1 : scl_q;
  assign sda = (sda_p1 == sda_p2 && sda_p2 == sda_p3) ? sda_p1 : sda_q;
`else
  assign scl = scl_p1;
  assign sda = sda_p1;
`endif

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C register-file slave: pointer byte then data writes, sequential reads.
// Define I2C_SLAVE_GLITCH_FILTER_EN to enable the SCL/SDA glitch filter.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter int         DATA_SIZE  = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         MEM_DEPTH  = 16
) (
  input  logic                         i2c_core_clk_i,
  input  logic                         reset_ni,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe_o,
  output logic                         busy_o,
  output logic                         rx_valid_o,
  output logic [DATA_SIZE-1:0]         rx_data_o,
  output logic [$clog2(MEM_DEPTH)-1:0] ptr_o
);

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int SH_W  = (DATA_SIZE > ADDR_BITS) ? DATA_SIZE : ADDR_BITS;
  localparam int HW    = SH_W - 1;
  localparam int CNT_W = $clog2(SH_W);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_SIZE - 1);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_slave_line_filter u_line (
    .clk      (i2c_core_clk_i),
    .rst_n    (reset_ni),
    .scl_raw  (scl_i),
    .sda_raw  (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 rw;
  logic                 sda_oe;
  logic                 busy;
  logic                 rx_valid;
  logic [DATA_SIZE-1:0] rx_data;
  logic [PTR_W-1:0]     ptr;

  logic [HW-1:0]        hist;
  logic [DATA_SIZE-1:0] rd_shift;
  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  logic [DATA_SIZE-1:0] byte_in;
  logic [DATA_SIZE-1:0] mem_word;

  assign byte_in  = {hist[DATA_SIZE-2:0], sda};
  assign mem_word = mem[ptr];

  logic ctl_free, rd_load_first, rd_load_next, rd_step;
  assign ctl_free      = !start && !stop;
  assign rd_load_first = ctl_free && (state == ADDR_ACK) && scl_fall && (bit_cnt != '0) && rw;
  assign rd_load_next  = ctl_free && (state == RD_ACK) && scl_rise && (sda == ACK_BIT);
  assign rd_step       = ctl_free && (state == RD) && scl_fall;

  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      ptr      <= '0;
    end else begin
      rx_valid <= 1'b0;
      // The byte captured last clock is being committed to memory now.
      if (rx_valid) ptr <= ptr + 1'b1;

      if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: ;

          ADDR: if (scl_rise) begin
            if (bit_cnt == LAST_ADDR) begin
              bit_cnt <= '0;
              if (hist[6:0] == SLAVE_ADDR) begin
                state <= ADDR_ACK;
                rw    <= sda;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          // First fall (8th) starts the ACK, second fall (9th) ends it.
          ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
            if (bit_cnt == '0) begin
              sda_oe  <= pull_for(ACK_BIT);
              bit_cnt <= CNT_W'(1);
            end else begin
              bit_cnt <= '0;
              if (state == ADDR_ACK && rw) begin
                state  <= RD;
                sda_oe <= pull_for(mem_word[DATA_SIZE-1]);
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ADDR_ACK) ? PTR : WR;
              end
            end
          end

          PTR: if (scl_rise) begin
            if (bit_cnt == LAST_DATA) begin
              ptr     <= byte_in[PTR_W-1:0];
              state   <= PTR_ACK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          WR: if (scl_rise) begin
            if (bit_cnt == LAST_DATA) begin
              rx_data  <= byte_in;
              rx_valid <= 1'b1;
              state    <= WR_ACK;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          RD: begin
            if (scl_rise) begin
              if (bit_cnt == LAST_DATA) begin
                state   <= RD_ACK;
                bit_cnt <= '0;
                ptr     <= ptr + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (scl_fall) begin
              sda_oe <= pull_for(rd_shift[DATA_SIZE-1]);
            end
          end

          RD_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              bit_cnt <= '0;
              if (sda == ACK_BIT) begin
                state <= RD;
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // Data path: bit history, read shifter and memory carry no reset.
  always_ff @(posedge i2c_core_clk_i) begin
    if (scl_rise) hist <= {hist[HW-2:0], sda};
    if (rd_load_first)     rd_shift <= mem_word << 1;
    else if (rd_load_next) rd_shift <= mem_word;
    else if (rd_step)      rd_shift <= rd_shift << 1;
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (rx_valid) mem[ptr] <= rx_data;
  end

  assign sda_oe_o   = sda_oe;
  assign busy_o     = busy;
  assign rx_valid_o = rx_valid;
  assign rx_data_o  = rx_data;
  assign ptr_o      = ptr;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged master with wired-AND SDA.
// The glitch scenario runs only when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_responder;

  localparam int Q = 6;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] ptr;
  wire        sda_w = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .i2c_core_clk_i (clk),
    .reset_ni       (rst_n),
    .scl_i          (scl_m),
    .sda_i          (sda_w),
    .sda_oe_o       (sda_oe),
    .busy_o         (busy),
    .rx_valid_o     (rx_valid),
    .rx_data_o      (rx_data),
    .ptr_o          (ptr)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic       clr = 1'b0;
  int         rx_cnt;
  logic [7:0] last_rx;
  logic       oe_seen;

  always @(posedge clk) begin
    if (clr) begin
      rx_cnt  <= 0;
      oe_seen <= 1'b0;
    end else begin
      if (rx_valid) begin
        rx_cnt  <= rx_cnt + 1;
        last_rx <= rx_data;
      end
      if (sda_oe) oe_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(H);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic clock_in(output logic b);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(H / 2);
    b = sda_w;
    tick(H / 2);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(H / 2);
    sda_m = 1'b0;
    tick(H / 2);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(H / 2);
    sda_m = 1'b1;
    tick(H / 2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    clock_in(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clock_in(b);
      d[i] = b;
    end
    send_bit(give_ack ? 1'b0 : 1'b1);
  endtask

  task automatic read_at(input logic [7:0] p, input string tag, input logic [7:0] exp);
    logic       a;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h78, a);
    write_byte(p, a);
    i2c_start();
    write_byte(8'h79, a);
    check({tag, "_addr_ack"}, a, 1'b1);
    read_byte(d, 1'b0);
    check(tag, d, exp);
    i2c_stop();
    tick(4);
  endtask

  logic       ack;
  logic [7:0] d;

  initial begin
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_ptr", ptr, 4'h0);
    rst_n = 1'b1;
    tick(5);

    // Write pointer 5, data 0xA5
    clear_mon();
    i2c_start();
    write_byte(8'h78, ack);
    check("wr_addr_ack", ack, 1'b1);
    check("wr_busy", busy, 1'b1);
    write_byte(8'h05, ack);
    check("wr_ptr_ack", ack, 1'b1);
    write_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1'b1);
    i2c_stop();
    tick(4);
    check("wr_rx_cnt", rx_cnt, 1);
    check("wr_last_rx", last_rx, 8'hA5);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_ptr", ptr, 4'h6);
    check("wr_busy_stop", busy, 1'b0);

    // Repeated-start read of mem[5], master NACK
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'h79, ack);
    check("rd_addr_ack", ack, 1'b1);
    read_byte(d, 1'b0);
    check("rd_data", d, 8'hA5);
    i2c_stop();
    tick(4);
    check("rd_busy_stop", busy, 1'b0);
    check("rd_ptr", ptr, 4'h6);
    check("rd_sda_oe", sda_oe, 1'b0);

    // Foreign address 0x50 must be ignored
    clear_mon();
    i2c_start();
    write_byte(8'hA0, ack);
    check("nak_addr", ack, 1'b0);
    check("nak_busy", busy, 1'b0);
    write_byte(8'h05, ack);
    check("nak_data", ack, 1'b0);
    i2c_stop();
    tick(4);
    check("nak_oe_seen", oe_seen, 1'b0);
    check("nak_rx_cnt", rx_cnt, 0);
    read_at(8'h05, "nak_mem5", 8'hA5);

    // Pointer wrap on writes and reads
    clear_mon();
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h11, ack);
    check("wrap_ack1", ack, 1'b1);
    write_byte(8'h22, ack);
    check("wrap_ack2", ack, 1'b1);
    i2c_stop();
    tick(4);
    check("wrap_ptr", ptr, 4'h1);
    check("wrap_rx_cnt", rx_cnt, 2);
    check("wrap_rx_data", rx_data, 8'h22);
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h0F, ack);
    i2c_start();
    write_byte(8'h79, ack);
    read_byte(d, 1'b1);
    check("wrap_rd15", d, 8'h11);
    read_byte(d, 1'b0);
    check("wrap_rd0", d, 8'h22);
    i2c_stop();
    tick(4);
    check("wrap_rd_ptr", ptr, 4'h1);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h78 >> i) & 8'h01) != 8'h00);
    check("rst_ack_driving", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    tick(1);
    check("rst_mid_busy", busy, 1'b0);
    sda_m = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    clear_mon();
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    check("rst_no_ack", oe_seen, 1'b0);
    check("rst_idle_busy", busy, 1'b0);
    check("rst_ptr_zero", ptr, 4'h0);
    i2c_stop();
    tick(4);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clock SCL low glitch during a data bit must be rejected
    clear_mon();
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h03, ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = ((8'h5A >> i) & 8'h01) != 8'h00;
      tick(Q);
      scl_m = 1'b1;
      tick(H / 2);
      if (i == 4) begin
        scl_m = 1'b0;
        tick(1);
        scl_m = 1'b1;
      end
      tick(H / 2);
      scl_m = 1'b0;
      tick(Q);
    end
    clock_in(d[0]);
    check("glitch_ack", d[0], 1'b0);
    i2c_stop();
    tick(4);
    check("glitch_rx_cnt", rx_cnt, 1);
    check("glitch_rx_data", rx_data, 8'h5A);
    check("glitch_ptr", ptr, 4'h4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 Parameter DATA_SIZE, default 8: byte width on the bus and width of each memory word.
REQ-002 Parameter SLAVE_ADDR, default 7'h3C: 7-bit address this slave answers.
REQ-003 Parameter MEM_DEPTH, default 16: number of internal register words; must be a power of 2.
REQ-004 i2c_core_clk_i  input  1  the only clock, oversampling SCL and SDA.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 scl_i  input  1  resolved SCL wire level, from the master's scl line.
REQ-007 sda_i  input  1  resolved SDA wire level.
REQ-008 sda_oe_o  output  1  1 = pull SDA low; 0 = release SDA. The slave never drives SDA high.
REQ-009 busy_o  output  1  1 from an addressed START until STOP.
REQ-010 rx_valid_o  output  1  one-clock pulse when a data byte is written to memory.
REQ-011 rx_data_o  output  DATA_SIZE  last byte written; holds until the next rx_valid_o.
REQ-012 ptr_o  output  log2(MEM_DEPTH)  current memory pointer.

Function
REQ-013 SCL/SDA shall pass through 2-flop synchronizers; the edge, START and STOP detectors shall use only the synchronized values.
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
REQ-016 START from any state (repeated start included) shall go to ADDR and clear the bit counter. STOP from any state shall go to IDLE.
REQ-017 The slave samples SDA on each SCL rising edge, MSB first. It changes sda_oe_o only on the clock after an SCL falling edge.
REQ-018 ADDR: after 8 bits, address equal to SLAVE_ADDR goes to ADDR_ACK. A mismatch goes to WAIT_STOP with sda_oe_o=0.
REQ-019 ADDR_ACK: sda_oe_o=1 from the 8th SCL fall to the 9th SCL fall. Next state: RD if R/W=1, else PTR.
REQ-020 PTR: the first write byte loads the pointer from its low log2(MEM_DEPTH) bits. ACK in PTR_ACK, then go to WR.
REQ-021 WR: each byte is stored to mem[ptr] one clock after the 8th SCL rise. rx_valid_o pulses in that same clock and the pointer increments. ACK in WR_ACK, then go back to WR.
REQ-022 RD: mem[ptr] is latched at the ADDR_ACK/RD_ACK exit. For each bit, sda_oe_o = ~bit. The pointer increments after the 8th bit.
REQ-023 RD_ACK: sda_oe_o=0. SDA low at the 9th rise (ACK) goes to RD. SDA high (NACK) goes to WAIT_STOP.
REQ-024 The pointer shall wrap from MEM_DEPTH-1 to 0 for both reads and writes.
REQ-025 busy_o=1 in every state except IDLE and WAIT_STOP.

Reset
REQ-026 While reset_ni=0:
- the state is IDLE;
- sda_oe_o=0 immediately (asynchronously);
- busy_o=0, rx_valid_o=0, rx_data_o=0, ptr_o=0;
- the synchronizers reset to 1.
REQ-027 Memory contents are not reset.
REQ-028 When reset releases mid-transfer, the slave shall stay in IDLE until the next START.

Configuration
REQ-029 Macro I2C_SLAVE_GLITCH_FILTER_EN defined: a synchronized SCL or SDA change is accepted only after it has been stable for 3 consecutive clocks. Detection latency grows by 2 clocks.
REQ-030 Macro undefined: the synchronizer outputs are used directly.

Structure
REQ-031 Package i2c_slave_pkg shall hold the FSM state enum and the ACK/NACK bit constants.
REQ-032 Sub-module i2c_slave_line_filter shall hold the synchronizers, the optional glitch filter and the SCL rise/fall and START/STOP pulse outputs.

Verification
REQ-033 START, 0x78, 0x05, 0xA5, STOP -> three ACKs, mem[5]=0xA5, one rx_valid_o pulse with rx_data_o=0xA5, ptr_o=6.
REQ-034 START, 0x78, 0x05, repeated START, 0x79, master NACK, STOP -> slave returns 0xA5 bit-exact on SDA; busy_o=0 after STOP.
REQ-035 START, 0xA0 (address 0x50) -> no ACK, sda_oe_o=0 throughout, busy_o=0, memory unchanged.
REQ-036 Write with pointer 0x0F, data 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22, ptr_o=1.
REQ-037 Assert reset_ni during ADDR_ACK -> sda_oe_o=0 in the same cycle; after release, SCL toggling without a START produces no ACK.
REQ-038 With I2C_SLAVE_GLITCH_FILTER_EN: a 1-clock SCL low glitch during WR -> no bit is counted and the byte is still received correctly. Without the macro, the same glitch corrupts the bit count (expected).
